vlt_sq_accum: RTL and testbench

VLT_SQ_ACCUM -- requirements
Module: vlt_sq_accum

---
 rtl/vlt_pkg.sv | 33 +++
 rtl/vlt_sat_add.sv | 22 ++
 rtl/vlt_sq_accum.sv | 158 +++++++++++++++
 tb/tb_vlt_sq_accum.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlt_pkg.sv
// rtl/vlt_pkg.sv - shared types, widths and term helper for the store-queue residency accumulator
package vlt_pkg;

    // Entry field widths and the exact width of a weighted residency term:
    // two terms of up to 1023 << 15 each, summed without loss.
    localparam int DUR_W   = 10;
    localparam int SHIFT_W = 4;
    localparam int TERM_W  = 26;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SNAP  = 2'd2
    } vlt_state_e;

    // Weighted residency of one entry: duration scaled by each enabled shift.
    function automatic logic [TERM_W-1:0] vlt_term(
        input logic [DUR_W-1:0]   dur,
        input logic [SHIFT_W-1:0] sh1,
        input logic               sh1_v,
        input logic [SHIFT_W-1:0] sh2,
        input logic               sh2_v
    );
        logic [TERM_W-1:0] ext;
        logic [TERM_W-1:0] t1;
        logic [TERM_W-1:0] t2;
        ext = TERM_W'(dur);
        t1  = sh1_v ? (ext << sh1) : '0;
        t2  = sh2_v ? (ext << sh2) : '0;
        return t1 + t2;
    endfunction

endpackage

// File: rtl/vlt_sat_add.sv
// rtl/vlt_sat_add.sv - unsigned saturating adder with overflow flag
//
// Ports:
//   a, b : W-bit unsigned addends
//   sum  : a + b, clipped to all-ones on overflow
//   ovf  : carry out of the W-bit add
module vlt_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[W];
    assign sum  = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/vlt_sq_accum.sv
// rtl/vlt_sq_accum.sv - accumulates weighted store-queue residency with drained snapshots
//
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   v_i / ready_o            : retire handshake for one store-queue entry
//   shift1_i, shift1_v_i     : first bit-weight shift and its enable
//   shift2_i, shift2_v_i     : second bit-weight shift and its enable
//   duration_i               : entry residency in cycles
//   snap_req_i               : request a drained snapshot of the totals
//   clear_i                  : zero totals and discard in-flight entries
//   snap_v_o                 : one-cycle pulse when the snapshot registers load
//   snap_acc_o, snap_cnt_o   : snapshot of accumulator and retired-entry count
//   sat_o                    : sticky accumulator-saturated flag
module vlt_sq_accum #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    output logic                ready_o,
    input  logic [3:0]          shift1_i,
    input  logic [3:0]          shift2_i,
    input  logic                shift1_v_i,
    input  logic                shift2_v_i,
    input  logic [9:0]          duration_i,
    input  logic                snap_req_i,
    input  logic                clear_i,
    output logic                snap_v_o,
    output logic [ACC_W-1:0]    snap_acc_o,
    output logic [CNT_W-1:0]    snap_cnt_o,
    output logic                sat_o
);

    import vlt_pkg::*;

    // The add runs at least TERM_W wide so a narrow accumulator still sees
    // the full term and clips instead of silently truncating it.
    localparam int ADD_W = (ACC_W > TERM_W) ? ACC_W : TERM_W;
    localparam logic [ADD_W-1:0] ACC_MAX_EXT = ADD_W'({ACC_W{1'b1}});
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    vlt_state_e        state;
    logic              accept;
    logic              s1_v;
    logic              s2_v;
    logic [TERM_W-1:0] term_q;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic [ADD_W-1:0]  add_a;
    logic [ADD_W-1:0]  add_b;
    logic [ADD_W-1:0]  add_sum;
    logic              add_ovf;
    logic              acc_clip;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_sum;
    logic              cnt_ovf;
    logic [CNT_W-1:0]  cnt_next;

    assign accept = v_i & ready_o;

    assign add_a = ADD_W'(acc);
    assign add_b = ADD_W'(term_q);

    vlt_sat_add #(.W(ADD_W)) u_acc_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign acc_clip = add_ovf | (add_sum > ACC_MAX_EXT);
    assign acc_next = acc_clip ? '1 : add_sum[ACC_W-1:0];

    vlt_sat_add #(.W(CNT_W)) u_cnt_add (
        .a   (cnt),
        .b   (CNT_ONE),
        .sum (cnt_sum),
        .ovf (cnt_ovf)
    );

    // Once the count has pinned at all-ones it simply holds.
    assign cnt_next = cnt_ovf ? cnt : cnt_sum;

    // Datapath: stage 1 captures the term, stage 2 folds it into the totals.
    // s2_v marks that the totals were updated on the last edge, so a drain
    // waits for that update to settle before the snapshot reads acc/cnt.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            term_q <= '0;
            acc    <= '0;
            cnt    <= '0;
            sat_o  <= 1'b0;
        end else if (clear_i) begin
            // Clear wins over both the new handshake and the in-flight term.
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            sat_o  <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            if (accept) begin
                term_q <= vlt_term(duration_i, shift1_i, shift1_v_i, shift2_i, shift2_v_i);
            end
            if (s1_v) begin
                acc <= acc_next;
                cnt <= cnt_next;
                if (acc_clip) begin
                    sat_o <= 1'b1;
                end
            end
        end
    end

    // Snapshot control. Clear does not touch this block, so a clear landing
    // on the SNAP cycle still captures the totals as they stood before it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_RUN;
            ready_o    <= 1'b1;
            snap_v_o   <= 1'b0;
            snap_acc_o <= '0;
            snap_cnt_o <= '0;
        end else begin
            snap_v_o <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (snap_req_i) begin
                        state   <= ST_DRAIN;
                        ready_o <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_v && !s2_v) begin
                        state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    snap_acc_o <= acc;
                    snap_cnt_o <= cnt;
                    snap_v_o   <= 1'b1;
                    state      <= ST_RUN;
                    ready_o    <= 1'b1;
                end
                default: begin
                    state   <= ST_RUN;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vlt_sq_accum.sv
// tb/tb_vlt_sq_accum.sv - scoreboard bench for vlt_sq_accum
module tb_vlt_sq_accum;

    localparam int ACC_W = 20;
    localparam int CNT_W = 5;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             v_i = 1'b0;
    logic             ready_o;
    logic [3:0]       shift1_i = '0;
    logic [3:0]       shift2_i = '0;
    logic             shift1_v_i = 1'b0;
    logic             shift2_v_i = 1'b0;
    logic [9:0]       duration_i = '0;
    logic             snap_req_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             snap_v_o;
    logic [ACC_W-1:0] snap_acc_o;
    logic [CNT_W-1:0] snap_cnt_o;
    logic             sat_o;

    always #5 clk = ~clk;

    vlt_sq_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .shift1_i   (shift1_i),
        .shift2_i   (shift2_i),
        .shift1_v_i (shift1_v_i),
        .shift2_v_i (shift2_v_i),
        .duration_i (duration_i),
        .snap_req_i (snap_req_i),
        .clear_i    (clear_i),
        .snap_v_o   (snap_v_o),
        .snap_acc_o (snap_acc_o),
        .snap_cnt_o (snap_cnt_o),
        .sat_o      (sat_o)
    );

    typedef struct {
        longint acc;
        longint cnt;
        bit     sat;
    } snap_t;

    snap_t  sb_q[$];
    snap_t  exp_s;
    int     checks = 0;
    int     failures = 0;
    int     cyc_n = 0;
    int     req_cyc = 0;
    int     snap_cyc = 0;
    int     snaps_seen = 0;

    // Reference totals: everything accepted since the last clear/reset.
    longint m_acc = 0;
    longint m_cnt = 0;
    bit     m_sat = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint term_of(input int d, input int s1, input bit s1v,
                                       input int s2, input bit s2v);
        longint t;
        t = 0;
        if (s1v) t += longint'(d) * (longint'(1) << s1);
        if (s2v) t += longint'(d) * (longint'(1) << s2);
        return t;
    endfunction

    // Monitor: every snapshot pulse consumes one expected record.
    always @(negedge clk) begin
        if (snap_v_o) begin
            snaps_seen++;
            snap_cyc = cyc_n;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_snap actual=acc %0d required=no pulse", snap_acc_o);
            end else begin
                exp_s = sb_q.pop_front();
                check("snap_acc", longint'(snap_acc_o), exp_s.acc);
                check("snap_cnt", longint'(snap_cnt_o), exp_s.cnt);
                check("snap_sat", longint'(sat_o), longint'(exp_s.sat));
            end
        end
    end

    // One clock cycle of stimulus. acc_ok is whether the bench expects the
    // block to be accepting entries in this cycle.
    task automatic cyc(input bit v, input int d, input int s1, input bit s1v,
                       input int s2, input bit s2v, input bit req, input bit clr,
                       input bit acc_ok);
        longint s;
        v_i        = v;
        duration_i = d[9:0];
        shift1_i   = s1[3:0];
        shift1_v_i = s1v;
        shift2_i   = s2[3:0];
        shift2_v_i = s2v;
        snap_req_i = req;
        clear_i    = clr;
        if (v) check("ready", longint'(ready_o), longint'(acc_ok));
        if (req) req_cyc = cyc_n;
        @(posedge clk);
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (v && acc_ok) begin
            s = m_acc + term_of(d, s1, s1v, s2, s2v);
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                m_sat = 1'b1;
            end
            m_acc = s;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (req && acc_ok) sb_q.push_back('{acc: m_acc, cnt: m_cnt, sat: m_sat});
        #1;
        v_i        = 1'b0;
        snap_req_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic entry(input int d, input int s1, input bit s1v, input int s2, input bit s2v);
        cyc(1, d, s1, s1v, s2, s2v, 0, 0, 1);
    endtask

    task automatic do_clear();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic snap_and_wait();
        int b;
        b = snaps_seen;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 30 && snaps_seen == b; i++) idle(1);
        check("snap_seen", longint'(snaps_seen - b), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int r;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("rst_ready", longint'(ready_o), 1);
        check("rst_snap_v", longint'(snap_v_o), 0);
        check("rst_snap_acc", longint'(snap_acc_o), 0);
        check("rst_snap_cnt", longint'(snap_cnt_o), 0);
        check("rst_sat", longint'(sat_o), 0);

        // Single entry 10 * (64 + 32), snapshot four cycles after the request
        entry(10, 6, 1, 5, 1);
        snap_and_wait();
        check("single_acc", longint'(snap_acc_o), 960);
        check("single_cnt", longint'(snap_cnt_o), 1);
        check("single_latency", longint'(snap_cyc - req_cyc), 4);

        // Three back-to-back entries, one with zero duration
        do_clear();
        entry(100, 6, 1, 3, 1);
        entry(50, 7, 1, 4, 1);
        entry(0, 6, 1, 3, 1);
        snap_and_wait();
        check("three_acc", longint'(snap_acc_o), 14400);
        check("three_cnt", longint'(snap_cnt_o), 3);

        // Both shifts disabled: count only
        entry(1023, 9, 0, 9, 0);
        snap_and_wait();
        check("noshift_acc", longint'(snap_acc_o), 14400);
        check("noshift_cnt", longint'(snap_cnt_o), 4);

        // Snapshot request with two entries in flight and v_i held high
        idle(3);
        b = snaps_seen;
        cyc(1, 5, 1, 1, 0, 0, 0, 0, 1);
        cyc(1, 7, 2, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 9, 3, 1, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 0, 0, 0, 0, 1);
        check("inflight_snap_count", longint'(snaps_seen - b), 1);
        check("inflight_acc", longint'(snap_acc_o), 14438);
        check("inflight_cnt", longint'(snap_cnt_o), 6);

        // Saturation: reach all-ones minus 5, then add 960
        do_clear();
        entry(1023, 10, 1, 0, 0);
        entry(1018, 0, 1, 0, 0);
        entry(10, 6, 1, 5, 1);
        snap_and_wait();
        check("sat_acc", longint'(snap_acc_o), ACC_MAX);
        check("sat_flag", longint'(sat_o), 1);
        entry(1, 0, 1, 0, 0);
        idle(4);
        check("sat_sticky", longint'(sat_o), 1);
        do_clear();
        check("sat_cleared", longint'(sat_o), 0);

        // Clear landing on the SNAP cycle
        entry(3, 2, 1, 0, 0);
        idle(3);
        b = snaps_seen;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        check("clrsnap_count", longint'(snaps_seen - b), 1);
        check("clrsnap_acc", longint'(snap_acc_o), 12);
        check("clrsnap_cnt", longint'(snap_cnt_o), 1);
        snap_and_wait();
        check("postclr_acc", longint'(snap_acc_o), 0);
        check("postclr_cnt", longint'(snap_cnt_o), 0);

        // Retired-entry counter pins at all-ones
        for (int i = 0; i < 40; i++) entry(0, 0, 1, 0, 1);
        snap_and_wait();
        check("cnt_sat", longint'(snap_cnt_o), CNT_MAX);

        // Reset in the middle of a drain: no pulse, outputs back to zero
        idle(3);
        entry(20, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        sb_q.delete();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        b = snaps_seen;
        idle(10);
        check("rstdrain_no_snap", longint'(snaps_seen), longint'(b));
        check("rstdrain_snap_acc", longint'(snap_acc_o), 0);
        check("rstdrain_snap_cnt", longint'(snap_cnt_o), 0);
        check("rstdrain_ready", longint'(ready_o), 1);

        // Randomised traffic with occasional clears and snapshots
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                snap_and_wait();
            end else begin
                cyc(r < 75,
                    int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)),
                    1'b0,
                    r >= 96,
                    1'b1);
            end
        end
        idle(3);
        snap_and_wait();
        check("scoreboard_empty", longint'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
